// File: rtl/rotary_stimulus_gen.sv
// Quadrature detent generator: turns one increment/decrement command
// into a full four-phase Gray sequence on the A/B channels.
module rotary_stimulus_gen #(
  parameter int PHASE_CYCLES = 4,
  parameter int COUNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_valid,
  input  logic               step_dir,
  output logic               step_ready,
  output logic               rotary_inc_a,
  output logic               rotary_inc_b,
  output logic               step_done,
  output logic               busy,
  output logic [COUNT_W-1:0] position
);

  typedef enum logic [2:0] {
    IDLE,
    PH1,
    PH2,
    PH3,
    GAP
  } state_t;

  localparam logic [7:0] RELOAD = 8'(PHASE_CYCLES - 1);

  state_t             state;
  state_t             state_n;
  logic [7:0]         cnt;
  logic [7:0]         cnt_n;
  logic               dir;
  logic               dir_n;
  logic               a_n;
  logic               b_n;
  logic               done_n;
  logic [COUNT_W-1:0] pos_n;
  logic               expire;

  assign expire     = (cnt == 8'd0);
  assign step_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  // Next state, phase counter, direction latch and position update
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dir_n   = dir;
    done_n  = 1'b0;
    pos_n   = position;
    unique case (state)
      IDLE: begin
        if (step_valid) begin
          state_n = PH1;
          cnt_n   = RELOAD;
          dir_n   = step_dir;
        end
      end
      PH1: begin
        if (expire) begin
          state_n = PH2;
          cnt_n   = RELOAD;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      PH2: begin
        if (expire) begin
          state_n = PH3;
          cnt_n   = RELOAD;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      PH3: begin
        if (expire) begin
          state_n = GAP;
          cnt_n   = RELOAD;
          done_n  = 1'b1;
          if (dir) begin
            pos_n = position + COUNT_W'(1);
          end else begin
            pos_n = position - COUNT_W'(1);
          end
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      GAP: begin
        if (expire) begin
          state_n = IDLE;
          cnt_n   = RELOAD;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 8'd0;
      end
    endcase
  end

  // Channel levels follow the state being entered so A/B are registered
  always_comb begin
    a_n = 1'b0;
    b_n = 1'b0;
    unique case (state_n)
      PH1: begin
        a_n = ~dir_n;
        b_n = dir_n;
      end
      PH2: begin
        a_n = 1'b1;
        b_n = 1'b1;
      end
      PH3: begin
        a_n = dir_n;
        b_n = ~dir_n;
      end
      default: begin
        a_n = 1'b0;
        b_n = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any partial detent silently
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      dir          <= 1'b0;
      rotary_inc_a <= 1'b0;
      rotary_inc_b <= 1'b0;
      step_done    <= 1'b0;
      position     <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      dir          <= dir_n;
      rotary_inc_a <= a_n;
      rotary_inc_b <= b_n;
      step_done    <= done_n;
      position     <= pos_n;
    end
  end

endmodule

// File: tb/tb_rotary_stimulus_gen.sv
// Bench for rotary_stimulus_gen: timeline model of one detent
// compared every cycle, plus directed literal checks.
module tb_rotary_stimulus_gen;

  localparam int P = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         step_valid = 1'b0;
  logic         step_dir = 1'b0;
  logic         step_ready;
  logic         rotary_inc_a;
  logic         rotary_inc_b;
  logic         step_done;
  logic         busy;
  logic [W-1:0] position;

  rotary_stimulus_gen #(
    .PHASE_CYCLES(P),
    .COUNT_W(W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .step_valid(step_valid),
    .step_dir(step_dir),
    .step_ready(step_ready),
    .rotary_inc_a(rotary_inc_a),
    .rotary_inc_b(rotary_inc_b),
    .step_done(step_done),
    .busy(busy),
    .position(position)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Model: a detent is a 4P-cycle timeline starting at the accept edge
  bit           chk_en = 1'b0;
  bit           act = 1'b0;
  int           t = 0;
  bit           mdir = 1'b0;
  logic [W-1:0] mpos = '0;
  int           cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      act    <= 1'b0;
      t      <= 0;
      mpos   <= '0;
      chk_en <= 1'b1;
    end else if (act) begin
      t <= t + 1;
      if (t + 1 == 3 * P)
        mpos <= mdir ? mpos + 8'd1 : mpos - 8'd1;
      if (t + 1 == 4 * P)
        act <= 1'b0;
    end else if (step_valid) begin
      act  <= 1'b1;
      t    <= 0;
      mdir <= step_dir;
    end
  end

  function automatic logic [1:0] exp_ab();
    logic [1:0] gray [4];
    logic [1:0] g;
    gray[0] = 2'b01;
    gray[1] = 2'b11;
    gray[2] = 2'b10;
    gray[3] = 2'b00;
    if (!act) return 2'b00;
    g = gray[t / P];
    return mdir ? g : {g[0], g[1]};
  endfunction

  int dones = 0;
  int done_cyc = 0;
  int last_rise = -1;
  int ready_cyc = 0;
  int gmin = 1000000;
  int gmax = 0;
  bit prev_busy = 1'b0;
  bit prev_ready = 1'b1;

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    logic [13:0] e;
    logic [13:0] g;
    if (chk_en) begin
      e = {exp_ab(), act && (t == 3 * P), act, !act, mpos};
      g = {rotary_inc_a, rotary_inc_b, step_done,
           busy, step_ready, position};
      checks++;
      if (e === g) passed++;
      else $display("FAIL cycle %0d outputs {a,b,done,busy,ready,pos} got %b want %b",
                    cyc, g, e);
      if (step_done) begin
        dones++;
        done_cyc = cyc;
      end
      if (busy && !prev_busy) begin
        if (last_rise >= 0) begin
          if (cyc - last_rise < gmin) gmin = cyc - last_rise;
          if (cyc - last_rise > gmax) gmax = cyc - last_rise;
        end
        last_rise = cyc;
      end
      if (step_ready && !prev_ready) ready_cyc = cyc;
      prev_busy  = busy;
      prev_ready = step_ready;
    end
  end

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(string name, int got, int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s got %0d want %0d", name, got, want);
  endtask

  task automatic pulse(bit d);
    step_valid = 1'b1;
    step_dir   = d;
    tick();
    step_valid = 1'b0;
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
  endtask

  int d0;
  int p0;
  int n;
  bit timeout;

  initial begin
    do_reset(3);
    check("reset_pos", int'(position), 0);
    check("reset_ready", int'(step_ready), 1);
    check("reset_ab", int'({rotary_inc_a, rotary_inc_b}), 0);
    tick(50);
    check("idle_no_done", dones, 0);

    pulse(1'b1);
    tick(20);
    check("inc_pos", int'(position), 1);
    check("inc_dones", dones, 1);
    check("inc_done_offset", done_cyc - last_rise, 12);
    check("inc_ready_offset", ready_cyc - last_rise, 16);

    do_reset(1);
    pulse(1'b0);
    tick(20);
    check("dec_pos", int'(position), 8'hFF);

    d0 = dones;
    p0 = int'(position);
    pulse(1'b1);
    tick(4);
    pulse(1'b1);
    tick(25);
    check("busy_rej_dones", dones - d0, 1);
    check("busy_rej_pos", (int'(position) - p0) & 8'hFF, 1);

    d0 = dones;
    pulse(1'b1);
    tick(4);
    check("mid_ph2_ab", int'({rotary_inc_a, rotary_inc_b}), 2'b11);
    do_reset(1);
    check("mid_rst_ab", int'({rotary_inc_a, rotary_inc_b}), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_pos", int'(position), 0);
    tick(20);
    check("mid_rst_dones", dones - d0, 0);

    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      step_valid = ($urandom_range(0, 3) == 0);
      step_dir   = $urandom_range(0, 1) == 1;
      tick();
    end
    reset      = 1'b0;
    step_valid = 1'b0;
    tick(20);

    do_reset(1);
    d0 = dones;
    last_rise = -1;
    gmin = 1000000;
    gmax = 0;
    step_dir   = 1'b1;
    step_valid = 1'b1;
    timeout = 1'b1;
    n = 0;
    while (n < 130 * 17 + 100) begin
      tick();
      n++;
      if (dones - d0 >= 130) begin
        timeout = 1'b0;
        break;
      end
    end
    step_valid = 1'b0;
    tick(20);
    check("wrap_timeout", int'(timeout), 0);
    check("wrap_dones", dones - d0, 130);
    check("wrap_gap_min", gmin, 17);
    check("wrap_gap_max", gmax, 17);
    check("wrap_pos", int'(position), 8'h82);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
